// File: rtl/multi_channel_divider.sv
// ----------------------------------------------------------------------------
// multi_channel_divider
//
// Purpose:
//   NUM_CH independent clock-enable strobe generators that share one clock.
//   Each channel has a runtime-programmable period (div+1 cycles) and runs
//   either periodically or as a one-shot. These strobes drive the IR/serial
//   samplers and timeout logic that need enables at assorted rates.
//
// Parameters:
//   NUM_CH      number of channels (1..16)
//   CNT_W       counter / divisor width in bits
//   DEFAULT_DIV divisor loaded into every channel at reset
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   cfg_we       configuration write strobe
//   cfg_ch       target channel of the write (out-of-range writes are ignored)
//   cfg_div      divisor, period = cfg_div+1 cycles
//   cfg_oneshot  1 = one-shot mode, 0 = periodic mode
//   cfg_phase    (MULTI_DIV_PHASE_EN only) start count on run rise / sync_clr
//   ch_run       per-channel run level
//   sync_clr     phase-align pulse, restarts every running counter
//   enable       one-cycle tick per channel
//   busy         channel is counting toward a tick
//
// Optional feature macro: MULTI_DIV_PHASE_EN (adds cfg_phase and start phase).
// ----------------------------------------------------------------------------
module multi_channel_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2024,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
`ifdef MULTI_DIV_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase,
`endif
    input  logic [NUM_CH-1:0] ch_run,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] enable,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Per-channel state: count, active divisor/mode and shadow divisor/mode.
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  div_q  [NUM_CH];
    logic [CNT_W-1:0]  div_d  [NUM_CH];
    logic [CNT_W-1:0]  sdiv_q [NUM_CH];
    logic [CNT_W-1:0]  sdiv_d [NUM_CH];
    logic [CNT_W-1:0]  start  [NUM_CH];
    logic [NUM_CH-1:0] os_q, os_d;
    logic [NUM_CH-1:0] sos_q, sos_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] term;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] upd;
    // Low for the first cycle after any reset edge; keeps enable/busy at 0
    // while reset is held even though ch_run may be high.
    logic              act_q;

`ifdef MULTI_DIV_PHASE_EN
    logic [CNT_W-1:0]  ph_q  [NUM_CH];
    logic [CNT_W-1:0]  ph_d  [NUM_CH];
    logic [CNT_W-1:0]  sph_q [NUM_CH];
    logic [CNT_W-1:0]  sph_d [NUM_CH];
    logic [NUM_CH-1:0] run_prev_q;
    logic [NUM_CH-1:0] rise;

    assign rise = ch_run & ~run_prev_q;
`endif

    // Terminal count on the registered count; only ch_run reaches the
    // outputs combinationally.
    always_comb begin
        term = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            term[i] = ch_run[i] & ~done_q[i] & (cnt_q[i] == div_q[i]);
        end
    end

    assign enable = term & {NUM_CH{act_q}};
    assign busy   = ch_run & ~done_q & {NUM_CH{act_q}};

    always_comb begin
        wr     = '0;
        upd    = '0;
        os_d   = os_q;
        sos_d  = sos_q;
        done_d = done_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            sdiv_d[i] = sdiv_q[i];
            start[i]  = '0;
`ifdef MULTI_DIV_PHASE_EN
            ph_d[i]   = ph_q[i];
            sph_d[i]  = sph_q[i];
`endif
            // Out-of-range cfg_ch matches no channel index, so it is dropped.
            wr[i] = cfg_we & (cfg_ch == CH_W'(i));
            if (wr[i]) begin
                sdiv_d[i] = cfg_div;
                sos_d[i]  = cfg_oneshot;
`ifdef MULTI_DIV_PHASE_EN
                sph_d[i]  = cfg_phase;
`endif
            end

            // Shadow equals active except while a write is pending, so the
            // copy can run on every idle or terminal cycle. Using the _d
            // shadow lets a write on the terminal cycle take effect for the
            // very next period.
            upd[i] = ~ch_run[i] | done_q[i] | term[i];
            if (upd[i]) begin
                div_d[i] = sdiv_d[i];
                os_d[i]  = sos_d[i];
`ifdef MULTI_DIV_PHASE_EN
                ph_d[i]  = sph_d[i];
`endif
            end

`ifdef MULTI_DIV_PHASE_EN
            start[i] = (ph_d[i] > div_d[i]) ? div_d[i] : ph_d[i];
`endif

            if (!ch_run[i]) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (done_q[i]) begin
                cnt_d[i] = '0;
            end else if (term[i]) begin
                if (os_q[i]) begin
                    done_d[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else if (sync_clr) begin
                    cnt_d[i] = start[i];
                end else begin
                    cnt_d[i] = '0;
                end
            end else if (sync_clr) begin
                cnt_d[i] = start[i];
`ifdef MULTI_DIV_PHASE_EN
            end else if (rise[i]) begin
                // Rise cycle itself plays the role of count==start, so the
                // next count is start+1 (saturated at div).
                cnt_d[i] = (start[i] == div_d[i]) ? start[i] : start[i] + CNT_ONE;
`endif
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DEF_DIV;
                sdiv_q[i] <= DEF_DIV;
`ifdef MULTI_DIV_PHASE_EN
                ph_q[i]   <= '0;
                sph_q[i]  <= '0;
`endif
            end
            os_q   <= '0;
            sos_q  <= '0;
            done_q <= '0;
            act_q  <= 1'b0;
`ifdef MULTI_DIV_PHASE_EN
            run_prev_q <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                sdiv_q[i] <= sdiv_d[i];
`ifdef MULTI_DIV_PHASE_EN
                ph_q[i]   <= ph_d[i];
                sph_q[i]  <= sph_d[i];
`endif
            end
            os_q   <= os_d;
            sos_q  <= sos_d;
            done_q <= done_d;
            act_q  <= 1'b1;
`ifdef MULTI_DIV_PHASE_EN
            run_prev_q <= ch_run;
`endif
        end
    end

endmodule

// File: tb/tb_multi_channel_divider.sv
`timescale 1ns/1ps
module tb_multi_channel_divider;

    // Three channels so that cfg_ch = 3 is an out-of-range write.
    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 16;
    localparam int unsigned DEF = 2024;
    localparam int unsigned CHW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_oneshot;
    logic [NCH-1:0] ch_run;
    logic           sync_clr;
    logic [NCH-1:0] enable;
    logic [NCH-1:0] busy;

    int n_cmp = 0;
    int n_bad = 0;

    multi_channel_divider #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .ch_run     (ch_run),
        .sync_clr   (sync_clr),
        .enable     (enable),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each channel keeps the absolute cycle number of its next tick.
    // A new period starting in cycle c with divisor d ticks in cycle c+d.
    // ------------------------------------------------------------------
    int             cyc = 0;
    bit             mvalid = 1'b0;
    bit             mrst = 1'b1;
    int             m_div  [NCH];
    int             m_sdiv [NCH];
    int             m_next [NCH];
    bit             m_os   [NCH];
    bit             m_sos  [NCH];
    bit             m_done [NCH];
    bit             m_tick;
    bit             m_old_os;
    logic [NCH-1:0] exp_en;
    logic [NCH-1:0] exp_busy;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            exp_busy[i] = !mrst && ch_run[i] && !m_done[i];
            exp_en[i]   = exp_busy[i] && (cyc == m_next[i]);
        end
        if (mvalid) begin
            check("enable_vs_model", int'(enable), int'(exp_en));
            check("busy_vs_model", int'(busy), int'(exp_busy));
        end
        // Advance the model with the inputs the DUT samples at the next edge.
        if (!reset_n) begin
            mvalid = 1'b1;
            mrst   = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                m_div[i]  = DEF;
                m_sdiv[i] = DEF;
                m_os[i]   = 1'b0;
                m_sos[i]  = 1'b0;
                m_done[i] = 1'b0;
                m_next[i] = cyc + 1 + int'(DEF);
            end
        end else begin
            mrst = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_tick   = ch_run[i] && !m_done[i] && (cyc == m_next[i]);
                m_old_os = m_os[i];
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_sdiv[i] = int'(cfg_div);
                    m_sos[i]  = cfg_oneshot;
                end
                if (!ch_run[i] || m_done[i] || m_tick) begin
                    m_div[i] = m_sdiv[i];
                    m_os[i]  = m_sos[i];
                end
                if (!ch_run[i]) begin
                    m_done[i] = 1'b0;
                    m_next[i] = cyc + 1 + m_div[i];
                end else if (m_done[i]) begin
                    m_next[i] = m_next[i];
                end else if (m_tick) begin
                    if (m_old_os) m_done[i] = 1'b1;
                    else          m_next[i] = cyc + 1 + m_div[i];
                end else if (sync_clr) begin
                    m_next[i] = cyc + 1 + m_div[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 2 time units after posedge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic write_cfg(input int ch, input int dv, input bit os);
        cfg_we      = 1'b1;
        cfg_ch      = CHW'(ch);
        cfg_div     = CW'(dv);
        cfg_oneshot = os;
        step(1);
        cfg_we      = 1'b0;
    endtask

    // Counts cycles from the next one (as 1) until enable[ch]; -1 on timeout.
    task automatic wait_tick(input int ch, input int limit, output int n,
                             output logic [NCH-1:0] vec);
        n   = 0;
        vec = '0;
        do begin
            @(negedge clk);
            n++;
            vec = enable;
        end while (!enable[ch] && n < limit);
        if (!enable[ch]) n = -1;
        @(posedge clk);
        #2;
    endtask

    task automatic sample(output logic [NCH-1:0] en, output logic [NCH-1:0] bs);
        @(negedge clk);
        en = enable;
        bs = busy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int             n;
        int             cntk;
        logic [NCH-1:0] v;
        logic [NCH-1:0] b;

        reset_n     = 1'b0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;
        ch_run      = '1;
        sync_clr    = 1'b0;

        // T1: reset held with all channels running, then default period.
        step(5);
        sample(v, b);
        check("t1_rst_enable", int'(v), 0);
        check("t1_rst_busy", int'(b), 0);
        reset_n = 1'b1;
        wait_tick(0, 3000, n, v);
        check("t1_first_tick", n, 2025);
        check("t1_all_channels", int'(v), 7);
        wait_tick(0, 3000, n, v);
        check("t1_period", n, 2025);
        ch_run = '0;
        step(1);

        // T2: periodic div=3, then div=0 (enable stuck high).
        write_cfg(1, 3, 1'b0);
        ch_run[1] = 1'b1;
        wait_tick(1, 50, n, v);
        check("t2_first_tick", n, 4);
        wait_tick(1, 50, n, v);
        check("t2_period_a", n, 4);
        wait_tick(1, 50, n, v);
        check("t2_period_b", n, 4);
        write_cfg(1, 0, 1'b0);
        wait_tick(1, 50, n, v);
        check("t2_pending_end", n, 3);
        cntk = 0;
        repeat (5) begin
            sample(v, b);
            cntk += int'(v[1]);
        end
        check("t2_div0_constant", cntk, 5);
        ch_run[1] = 1'b0;

        // T3: one-shot div=5.
        write_cfg(2, 5, 1'b1);
        ch_run[2] = 1'b1;
        wait_tick(2, 50, n, v);
        check("t3_tick", n, 6);
        sample(v, b);
        check("t3_busy_after", int'(b[2]), 0);
        cntk = 0;
        repeat (20) begin
            sample(v, b);
            cntk += int'(v[2]);
        end
        check("t3_no_retick", cntk, 0);
        ch_run[2] = 1'b0;
        step(1);
        ch_run[2] = 1'b1;
        wait_tick(2, 50, n, v);
        check("t3_rearm", n, 6);
        ch_run[2] = 1'b0;

        // T4: shadow update mid-count, then out-of-range write.
        write_cfg(0, 9, 1'b0);
        ch_run[0] = 1'b1;
        step(4);
        write_cfg(0, 2, 1'b0);
        wait_tick(0, 50, n, v);
        check("t4_old_period_end", n, 5);
        wait_tick(0, 50, n, v);
        check("t4_new_period", n, 3);
        write_cfg(3, 0, 1'b1);
        wait_tick(0, 50, n, v);
        check("t4_oob_ignored_a", n, 2);
        wait_tick(0, 50, n, v);
        check("t4_oob_ignored_b", n, 3);

        // T5: sync_clr aligns ch0 (div 7) and ch1 (div 3).
        write_cfg(0, 7, 1'b0);
        write_cfg(1, 3, 1'b0);
        ch_run[1] = 1'b1;
        step(5);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        wait_tick(0, 50, n, v);
        check("t5_ch0_after_clr", n, 8);
        check("t5_coincide_a", int'(v), 3);
        wait_tick(1, 50, n, v);
        check("t5_ch1_period", n, 4);
        check("t5_ch1_alone", int'(v), 2);
        wait_tick(0, 50, n, v);
        check("t5_ch0_next", n, 4);
        check("t5_coincide_b", int'(v), 3);

        // T6: reset in the middle of a long count.
        ch_run = '0;
        step(1);
        write_cfg(0, 2024, 1'b0);
        ch_run[0] = 1'b1;
        step(1000);
        reset_n = 1'b0;
        step(1);
        sample(v, b);
        check("t6_rst_enable", int'(v), 0);
        check("t6_rst_busy", int'(b), 0);
        reset_n = 1'b1;
        wait_tick(0, 3000, n, v);
        check("t6_after_reset", n, 2025);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
